rv32i_instr_encoder: RTL and testbench

- Inverse of the main control decoder: takes symbolic instruction requests (class, funct3, alt bit, registers, immediate) over a valid/ready handshake.
- Encodes each request into a 32-bit RV32I word, buffers it in a FIFO, and writes it sequentially into instruction memory from a base address.
- Used as the program loader and self-test generator in front of imem.

---
 rtl/rv32i_instr_encoder.sv | 171 +++++++++++++++++
 tb/tb_rv32i_instr_encoder.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_instr_encoder.sv
// Symbolic RV32I request encoder and sequential instruction-memory loader.
// Requests are encoded on acceptance, queued in a small FIFO, and written out through a register.
module rv32i_instr_encoder #(
   parameter int unsigned ADDR_W = 10,
   parameter int unsigned DEPTH  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [2:0]        req_class,
   input  logic [2:0]        req_funct3,
   input  logic              req_alt,
   input  logic [4:0]        req_rd,
   input  logic [4:0]        req_rs1,
   input  logic [4:0]        req_rs2,
   input  logic [31:0]       req_imm,
   input  logic              req_last,
   output logic              imem_we,
   input  logic              imem_ready,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [ADDR_W:0]   count
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam logic [PW:0]     PtrOne   = (PW+1)'(1);
   localparam logic [ADDR_W-1:0] AddrOne = ADDR_W'(1);
   localparam logic [ADDR_W:0]   CntOne  = (ADDR_W+1)'(1);

   typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

   state_e            state_q, state_d;
   logic [31:0]       fifo_mem [DEPTH];
   logic [PW:0]       fifo_wr_q, fifo_rd_q;
   logic              fifo_empty, fifo_full;
   logic              out_valid_q;
   logic [31:0]       out_data_q;
   logic [ADDR_W-1:0] wptr_q;
   logic [ADDR_W:0]   count_q;
   logic              err_q;

   logic              accept, push, pop, ack, drop;
   logic [31:0]       enc;
   logic              fits_i, fits_b, fits_j, fits_sh, is_shift;

   assign fifo_empty = (fifo_wr_q == fifo_rd_q);
   assign fifo_full  = (fifo_wr_q[PW] != fifo_rd_q[PW]) &&
                       (fifo_wr_q[PW-1:0] == fifo_rd_q[PW-1:0]);

   assign req_ready = (state_q == StRun) && !fifo_full;
   assign accept    = req_valid && req_ready;
   assign push      = accept && !drop;
   assign ack       = out_valid_q && imem_ready;
   assign pop       = !fifo_empty && (!out_valid_q || imem_ready);

   // Sign-extension checks: the bits above each field's MSB must all match it.
   assign fits_i   = (&req_imm[31:11]) || !(|req_imm[31:11]);
   assign fits_b   = ((&req_imm[31:12]) || !(|req_imm[31:12])) && !req_imm[0];
   assign fits_j   = ((&req_imm[31:20]) || !(|req_imm[31:20])) && !req_imm[0];
   assign fits_sh  = !(|req_imm[31:5]);
   assign is_shift = (req_funct3 == 3'b001) || (req_funct3 == 3'b101);

   always_comb begin
      enc  = '0;
      drop = 1'b0;
      case (req_class)
         3'd0: begin
            enc  = {req_imm[11:0], req_rs1, req_funct3, req_rd, 7'b0000011};
            drop = !fits_i;
         end
         3'd1: begin
            enc  = {req_imm[11:5], req_rs2, req_rs1, req_funct3, req_imm[4:0], 7'b0100011};
            drop = !fits_i;
         end
         3'd2: begin
            enc = {1'b0, req_alt, 5'b00000, req_rs2, req_rs1, req_funct3, req_rd, 7'b0110011};
         end
         3'd3: begin
            enc  = {req_imm[12], req_imm[10:5], req_rs2, req_rs1, req_funct3,
                    req_imm[4:1], req_imm[11], 7'b1100011};
            drop = !fits_b;
         end
         3'd4: begin
            if (is_shift) begin
               enc  = {1'b0, req_alt, 5'b00000, req_imm[4:0], req_rs1, req_funct3, req_rd,
                       7'b0010011};
               drop = !fits_sh;
            end else begin
               enc  = {req_imm[11:0], req_rs1, req_funct3, req_rd, 7'b0010011};
               drop = !fits_i;
            end
         end
         3'd5: begin
            enc  = {req_imm[20], req_imm[10:1], req_imm[11], req_imm[19:12], req_rd, 7'b1101111};
            drop = !fits_j;
         end
         3'd6: begin
            enc = {req_imm[31:12], req_rd, 7'b0110111};
         end
         default: begin
            drop = 1'b1;
         end
      endcase
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle:  if (start) state_d = StRun;
         StRun:   if (accept && req_last) state_d = StDrain;
         StDrain: if (fifo_empty && !out_valid_q) state_d = StDone;
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[fifo_wr_q[PW-1:0]] <= enc;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         fifo_wr_q   <= '0;
         fifo_rd_q   <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         wptr_q      <= '0;
         count_q     <= '0;
         err_q       <= 1'b0;
      end else begin
         state_q <= state_d;
         if (push) fifo_wr_q <= fifo_wr_q + PtrOne;
         if (pop) begin
            fifo_rd_q   <= fifo_rd_q + PtrOne;
            out_valid_q <= 1'b1;
            out_data_q  <= fifo_mem[fifo_rd_q[PW-1:0]];
         end else if (ack) begin
            out_valid_q <= 1'b0;
         end
         if (state_q == StIdle && start) begin
            wptr_q  <= base_addr;
            count_q <= '0;
            err_q   <= 1'b0;
         end else begin
            if (ack) begin
               wptr_q <= wptr_q + AddrOne;
               if (count_q != '1) count_q <= count_q + CntOne;
            end
            if (accept && drop) err_q <= 1'b1;
         end
      end
   end

   assign imem_we    = out_valid_q;
   assign imem_addr  = wptr_q;
   assign imem_wdata = out_data_q;
   assign busy       = (state_q != StIdle);
   assign done       = (state_q == StDone);
   assign err        = err_q;
   assign count      = count_q;

endmodule

// File: tb/tb_rv32i_instr_encoder.sv
// Directed bench for rv32i_instr_encoder: hand-encoded RV32I words, back-pressure, drops, reset.
module tb_rv32i_instr_encoder;

   localparam int unsigned ADDR_W = 10;
   localparam int unsigned DEPTH  = 4;

   logic              clk = 1'b0;
   logic              rst, start, req_valid, req_ready, req_alt, req_last;
   logic [ADDR_W-1:0] base_addr;
   logic [2:0]        req_class, req_funct3;
   logic [4:0]        req_rd, req_rs1, req_rs2;
   logic [31:0]       req_imm;
   logic              imem_we, imem_ready, busy, done, err;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_wdata;
   logic [ADDR_W:0]   count;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   logic [ADDR_W-1:0] wa[$];
   logic [31:0]       wd[$];
   int                wc[$];

   rv32i_instr_encoder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
      .req_valid(req_valid), .req_ready(req_ready), .req_class(req_class),
      .req_funct3(req_funct3), .req_alt(req_alt), .req_rd(req_rd), .req_rs1(req_rs1),
      .req_rs2(req_rs2), .req_imm(req_imm), .req_last(req_last),
      .imem_we(imem_we), .imem_ready(imem_ready), .imem_addr(imem_addr),
      .imem_wdata(imem_wdata), .busy(busy), .done(done), .err(err), .count(count)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (!rst && imem_we && imem_ready) begin
         wa.push_back(imem_addr);
         wd.push_back(imem_wdata);
         wc.push_back(cyc);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
      $fatal(1, "watchdog");
   end

   task automatic clear_log();
      wa.delete(); wd.delete(); wc.delete();
   endtask

   task automatic start_session(input logic [ADDR_W-1:0] b);
      start = 1'b1; base_addr = b;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic send_req(input logic [2:0] cls, input logic [2:0] f3, input logic alt,
                           input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic [31:0] imm, input logic last, output bit ok);
      bit acc;
      ok = 1'b0;
      req_class = cls; req_funct3 = f3; req_alt = alt; req_rd = rd; req_rs1 = rs1;
      req_rs2 = rs2; req_imm = imm; req_last = last; req_valid = 1'b1;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         acc = req_ready;
         @(posedge clk); #1;
         if (acc) begin ok = 1'b1; break; end
      end
      req_valid = 1'b0; req_last = 1'b0;
   endtask

   task automatic wait_done(output bit seen);
      seen = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (done) begin seen = 1'b1; break; end
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({imem_we, busy, done, err, req_ready} !== 5'b0) begin
         errors++;
         $display("FAIL reset_flags: got we/busy/done/err/ready=%b required 00000",
                  {imem_we, busy, done, err, req_ready});
      end
      checks++;
      if (count !== '0 || imem_addr !== '0 || imem_wdata !== '0) begin
         errors++;
         $display("FAIL reset_values: got count=%0d addr=%h wdata=%h required 0/0/0",
                  count, imem_addr, imem_wdata);
      end
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_addi();
      bit ok, seen;
      clear_log();
      imem_ready = 1'b1;
      start_session(10'h010);
      send_req(3'd4, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b1, ok);
      checks++;
      if (!ok || imem_we !== 1'b0) begin
         errors++;
         $display("FAIL addi_latency1: got accepted=%0d we=%b required 1 and 0", ok, imem_we);
      end
      @(posedge clk); #1;
      checks++;
      if (imem_we !== 1'b1 || imem_addr !== 10'h010) begin
         errors++;
         $display("FAIL addi_latency2: got we=%b addr=%h required 1 and 010", imem_we, imem_addr);
      end
      wait_done(seen);
      checks++;
      if (!seen || wa.size() != 1) begin
         errors++;
         $display("FAIL addi_done: got done=%0d writes=%0d required 1 and 1", seen, wa.size());
      end else begin
         checks++;
         if (wa[0] !== 10'h010 || wd[0] !== 32'h00500093) begin
            errors++;
            $display("FAIL addi_word: got %h@%h required 00500093@010", wd[0], wa[0]);
         end
      end
      checks++;
      if (count !== 11'd1 || err !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL addi_status: got count=%0d err=%b busy=%b required 1/0/0",
                  count, err, busy);
      end
   endtask

   task automatic test_back_to_back();
      bit ok1, ok2, seen;
      clear_log();
      start_session(10'h020);
      send_req(3'd2, 3'b000, 1'b1, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0, ok1);
      send_req(3'd1, 3'b010, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8, 1'b1, ok2);
      wait_done(seen);
      checks++;
      if (!ok1 || !ok2 || !seen || wa.size() != 2) begin
         errors++;
         $display("FAIL b2b_count: got acc=%0d%0d done=%0d writes=%0d required 11/1/2",
                  ok1, ok2, seen, wa.size());
      end else begin
         checks++;
         if (wa[0] !== 10'h020 || wd[0] !== 32'h402081B3 ||
             wa[1] !== 10'h021 || wd[1] !== 32'h0020A423) begin
            errors++;
            $display("FAIL b2b_words: got %h@%h %h@%h required 402081b3@020 0020a423@021",
                     wd[0], wa[0], wd[1], wa[1]);
         end
         checks++;
         if (wc[1] != wc[0] + 1) begin
            errors++;
            $display("FAIL b2b_cycles: got gap=%0d required 1", wc[1] - wc[0]);
         end
      end
   endtask

   task automatic test_encodings();
      bit ok, seen;
      logic [31:0] exp [5];
      exp[0] = 32'hFE208EE3; exp[1] = 32'h4032D293; exp[2] = 32'h001000EF;
      exp[3] = 32'hFFF32283; exp[4] = 32'h123453B7;
      clear_log();
      start_session(10'h040);
      send_req(3'd3, 3'b000, 1'b0, 5'd0, 5'd1, 5'd2, -32'sd4, 1'b0, ok);
      send_req(3'd4, 3'b101, 1'b1, 5'd5, 5'd5, 5'd0, 32'd3, 1'b0, ok);
      send_req(3'd5, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd2048, 1'b0, ok);
      send_req(3'd0, 3'b010, 1'b0, 5'd5, 5'd6, 5'd0, 32'hFFFF_FFFF, 1'b0, ok);
      send_req(3'd6, 3'b000, 1'b0, 5'd7, 5'd0, 5'd0, 32'h1234_5ABC, 1'b1, ok);
      wait_done(seen);
      checks++;
      if (!seen || wa.size() != 5) begin
         errors++;
         $display("FAIL enc_count: got done=%0d writes=%0d required 1 and 5", seen, wa.size());
      end else begin
         for (int i = 0; i < 5; i++) begin
            checks++;
            if (wd[i] !== exp[i] || wa[i] !== 10'h040 + 10'(i)) begin
               errors++;
               $display("FAIL enc_word%0d: got %h@%h required %h@%h", i, wd[i], wa[i],
                        exp[i], 10'h040 + 10'(i));
            end
         end
      end
   endtask

   task automatic test_backpressure();
      bit ok, seen, acc, have_held, ready_now;
      int k, acc_n, held_bad, bad_words;
      logic [ADDR_W-1:0] h_addr;
      logic [31:0]       h_data, e;
      clear_log();
      imem_ready = 1'b0;
      start_session(10'h080);
      k = 0; acc_n = 0; held_bad = 0; have_held = 1'b0; h_addr = '0; h_data = '0;
      req_class = 3'd4; req_funct3 = 3'b000; req_alt = 1'b0; req_rs1 = 5'd0; req_rs2 = 5'd0;
      req_rd = 5'd1; req_imm = 32'd0; req_last = 1'b0; req_valid = 1'b1;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         acc = req_ready;
         if (imem_we) begin
            if (!have_held) begin
               h_addr = imem_addr; h_data = imem_wdata; have_held = 1'b1;
            end else if (imem_addr !== h_addr || imem_wdata !== h_data) begin
               held_bad++;
            end
         end
         @(posedge clk); #1;
         if (acc) begin
            acc_n++; k++; req_rd = 5'(k + 1); req_imm = 32'(k);
         end
      end
      @(negedge clk);
      ready_now = req_ready;
      checks++;
      if (acc_n != 5 || ready_now !== 1'b0) begin
         errors++;
         $display("FAIL bp_accepted: got %0d ready=%b required 5 and 0", acc_n, ready_now);
      end
      checks++;
      if (!have_held || held_bad != 0 || h_addr !== 10'h080 || h_data !== 32'h00000093) begin
         errors++;
         $display("FAIL bp_hold: got %h@%h changes=%0d required 00000093@080 0 changes",
                  h_data, h_addr, held_bad);
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
      imem_ready = 1'b1;
      send_req(3'd4, 3'b000, 1'b0, 5'd6, 5'd0, 5'd0, 32'd5, 1'b1, ok);
      wait_done(seen);
      checks++;
      if (!seen || wa.size() != 6 || count !== 11'd6) begin
         errors++;
         $display("FAIL bp_drain: got done=%0d writes=%0d count=%0d required 1/6/6",
                  seen, wa.size(), count);
      end else begin
         bad_words = 0;
         for (int i = 0; i < 6; i++) begin
            e = (32'(i) << 20) | (32'(i + 1) << 7) | 32'h13;
            if (wd[i] !== e || wa[i] !== 10'h080 + 10'(i)) bad_words++;
         end
         checks++;
         if (bad_words != 0) begin
            errors++;
            $display("FAIL bp_order: got %0d misplaced words required 0", bad_words);
         end
      end
   endtask

   task automatic test_errors();
      bit ok, seen;
      clear_log();
      start_session(10'h100);
      send_req(3'd4, 3'b000, 1'b0, 5'd2, 5'd0, 5'd0, 32'd7, 1'b0, ok);
      send_req(3'd3, 3'b000, 1'b0, 5'd0, 5'd1, 5'd2, 32'd3, 1'b0, ok);
      checks++;
      if (!ok || err !== 1'b1) begin
         errors++;
         $display("FAIL err_branch_odd: got accepted=%0d err=%b required 1 and 1", ok, err);
      end
      send_req(3'd4, 3'b000, 1'b0, 5'd2, 5'd0, 5'd0, 32'd2048, 1'b0, ok);
      send_req(3'd4, 3'b001, 1'b0, 5'd2, 5'd2, 5'd0, 32'd32, 1'b0, ok);
      send_req(3'd5, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd1, 1'b0, ok);
      send_req(3'd7, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd0, 1'b1, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL err_illegal_accept: got accepted=0 required 1");
      end
      wait_done(seen);
      checks++;
      if (!seen || wa.size() != 1 || count !== 11'd1 || err !== 1'b1) begin
         errors++;
         $display("FAIL err_summary: got done=%0d writes=%0d count=%0d err=%b required 1/1/1/1",
                  seen, wa.size(), count, err);
      end else begin
         checks++;
         if (wd[0] !== 32'h00700113 || wa[0] !== 10'h100) begin
            errors++;
            $display("FAIL err_good_word: got %h@%h required 00700113@100", wd[0], wa[0]);
         end
      end
   endtask

   task automatic test_reset_wrap();
      bit ok, seen;
      imem_ready = 1'b0;
      start_session(10'h200);
      checks++;
      if (err !== 1'b0) begin
         errors++;
         $display("FAIL err_cleared_on_start: got err=%b required 0", err);
      end
      send_req(3'd4, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd1, 1'b0, ok);
      send_req(3'd4, 3'b000, 1'b0, 5'd2, 5'd0, 5'd0, 32'd2, 1'b0, ok);
      send_req(3'd4, 3'b000, 1'b0, 5'd3, 5'd0, 5'd0, 32'd3, 1'b1, ok);
      checks++;
      if (busy !== 1'b1 || imem_we !== 1'b1) begin
         errors++;
         $display("FAIL drain_state: got busy=%b we=%b required 1 and 1", busy, imem_we);
      end
      rst = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (imem_we !== 1'b0 || busy !== 1'b0 || count !== '0) begin
         errors++;
         $display("FAIL mid_reset: got we=%b busy=%b count=%0d required 0/0/0",
                  imem_we, busy, count);
      end
      rst = 1'b0;
      imem_ready = 1'b1;
      clear_log();
      start_session(10'h3FF);
      send_req(3'd6, 3'b000, 1'b0, 5'd7, 5'd0, 5'd0, 32'h1234_5000, 1'b0, ok);
      send_req(3'd4, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b1, ok);
      wait_done(seen);
      checks++;
      if (!seen || wa.size() != 2 || count !== 11'd2) begin
         errors++;
         $display("FAIL wrap_count: got done=%0d writes=%0d count=%0d required 1/2/2",
                  seen, wa.size(), count);
      end else begin
         checks++;
         if (wa[0] !== 10'h3FF || wd[0] !== 32'h123453B7 ||
             wa[1] !== 10'h000 || wd[1] !== 32'h00500093) begin
            errors++;
            $display("FAIL wrap_words: got %h@%h %h@%h required 123453b7@3ff 00500093@000",
                     wd[0], wa[0], wd[1], wa[1]);
         end
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; base_addr = '0; req_valid = 1'b0; req_class = '0;
      req_funct3 = '0; req_alt = 1'b0; req_rd = '0; req_rs1 = '0; req_rs2 = '0;
      req_imm = '0; req_last = 1'b0; imem_ready = 1'b1;
      test_reset();
      test_addi();
      test_back_to_back();
      test_encodings();
      test_backpressure();
      test_errors();
      test_reset_wrap();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
